// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// byte-enable and funct3-legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    // size is funct3[1:0]: 00 byte, 01 halfword, 10 word
    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << {offset[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic f3_valid(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load lane select with sign/zero extension.
module load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = mem_rdata[7:0];
        case (offset)
            2'd0: lane_b = mem_rdata[7:0];
            2'd1: lane_b = mem_rdata[15:8];
            2'd2: lane_b = mem_rdata[23:16];
            2'd3: lane_b = mem_rdata[31:24];
            default: lane_b = mem_rdata[7:0];
        endcase
        lane_h = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        result = mem_rdata;
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_BU:   result = {24'd0, lane_b};
            F3_HU:   result = {16'd0, lane_h};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: single-outstanding req/ack data bus master.
// Build option LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of being aligned.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output lsu_state_e      state_dbg
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // Handshake: mem_req is held with stable addr/we/be/wdata until the
    // cycle mem_ack is seen high; mem_ack at any other time is ignored.
    lsu_state_e      state, state_nx;
    logic [CW-1:0]   cnt;
    logic            err_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] ext_data;
    logic [XLEN-1:0] addr_al;
    logic [XLEN-1:0] wdata_st;
    logic            fault;
    logic            accept;
    logic            reject;
    logic            timeout_hit;

    always_comb begin
        addr_al = addr;
        if (funct3[1:0] == 2'b01) addr_al[0]   = 1'b0;
        if (funct3[1:0] == 2'b10) addr_al[1:0] = 2'b00;
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   wdata_st = {4{wdata[7:0]}};
            2'b01:   wdata_st = {2{wdata[15:0]}};
            default: wdata_st = wdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign fault = !f3_valid(we, funct3) ||
                   ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign fault = !f3_valid(we, funct3);
`endif

    assign timeout_hit = (cnt == CNT_LAST);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (fault) begin
                        reject   = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        accept   = 1'b1;
                        state_nx = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack || timeout_hit) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            err_q     <= 1'b0;
            rdata     <= '0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt       <= '0;
                f3_q      <= funct3;
                off_q     <= addr_al[1:0];
                mem_we    <= we;
                mem_be    <= be_for(funct3[1:0], addr_al[1:0]);
                mem_addr  <= {addr_al[XLEN-1:2], 2'b00};
                mem_wdata <= wdata_st;
            end
            if (reject) err_q <= 1'b1;
            if (state == S_REQ) begin
                if (mem_ack) begin
                    if (!mem_we) rdata <= ext_data;
                    err_q <= 1'b0;
                end else if (timeout_hit) begin
                    err_q <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    load_extend #(.XLEN(XLEN)) u_ext (
        .mem_rdata (mem_rdata),
        .offset    (off_q),
        .funct3    (f3_q),
        .result    (ext_data)
    );

    assign mem_req   = (state == S_REQ);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = done & err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: main instance (TIMEOUT=255) plus a TIMEOUT=4 instance.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start, start_t;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        mem_ack, mem_ack_t;

    logic        busy, done, err, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] rdata, mem_addr, mem_wdata;
    lsu_state_e  state_dbg;

    logic        busy_t, done_t, err_t, mem_req_t, mem_we_t;
    logic [3:0]  mem_be_t;
    logic [31:0] rdata_t, mem_addr_t, mem_wdata_t;
    lsu_state_e  state_dbg_t;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    lsu #(.XLEN(32), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .start(start), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .state_dbg(state_dbg)
    );

    lsu #(.XLEN(32), .TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .start(start_t), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy_t), .done(done_t), .err(err_t),
        .rdata(rdata_t), .mem_req(mem_req_t), .mem_we(mem_we_t), .mem_be(mem_be_t),
        .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack_t), .state_dbg(state_dbg_t)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: strobe start for one cycle; returns 1 time unit into cycle 1
    task automatic issue(input logic t, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        we = w; funct3 = f3; addr = a; wdata = d;
        if (t) start_t = 1'b1; else start = 1'b1;
        step();
        start = 1'b0; start_t = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_t = 1'b0; we = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0; mem_ack_t = 1'b0;
        step(); step();

        // reset values
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_err", err, 0);         chk("rst_rdata", rdata, 0);
        chk("rst_req", mem_req, 0);     chk("rst_we", mem_we, 0);
        chk("rst_be", mem_be, 0);       chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0); chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        reset = 1'b0;
        step();

        // ack while idle is ignored
        mem_ack = 1'b1; step(); chk("idle_ack_busy", busy, 0); mem_ack = 1'b0;

        // SW 0x104
        issue(0, 1, F3_W, 32'h104, 32'hDEADBEEF);
        chk("sw_req", mem_req, 1);       chk("sw_we", mem_we, 1);
        chk("sw_addr", mem_addr, 32'h104); chk("sw_be", mem_be, 4'b1111);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF); chk("sw_busy", busy, 1);
        chk("sw_done_c1", done, 0);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk("sw_done", done, 1); chk("sw_err", err, 0); chk("sw_req_c2", mem_req, 0);
        step();
        chk("sw_done_drop", done, 0); chk("sw_busy_drop", busy, 0);

        // SB 0x203
        issue(0, 1, F3_B, 32'h203, 32'h000000A5);
        chk("sb_be", mem_be, 4'b1000); chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("sb_addr", mem_addr, 32'h200);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk("sb_done", done, 1); step();

        // SH 0x406
        issue(0, 1, F3_H, 32'h406, 32'h1234BEEF);
        chk("sh_be", mem_be, 4'b1100); chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        mem_ack = 1'b1; step(); mem_ack = 1'b0; step();

        // LB / LBU 0x302
        mem_rdata = 32'h12F04455;
        exp_q.push_back(32'hFFFFFFF0);
        exp_q.push_back(32'h000000F0);
        issue(0, 0, F3_B, 32'h302, 32'd0);
        chk("lb_be", mem_be, 4'b0100); chk("lb_we", mem_we, 0);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        exp_v = exp_q.pop_front();
        chk("lb_done", done, 1); chk("lb_rdata", rdata, exp_v);
        step();
        chk("lb_rdata_hold", rdata, exp_v);
        issue(0, 0, F3_BU, 32'h302, 32'd0);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        exp_v = exp_q.pop_front();
        chk("lbu_rdata", rdata, exp_v); step();

        // LH 0x402, ack on cycle 5
        mem_rdata = 32'h80017FFF;
        exp_q.push_back(32'hFFFF8001);
        issue(0, 0, F3_H, 32'h402, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("lh_req_c%0d", c), mem_req, 1);
            chk($sformatf("lh_addr_c%0d", c), mem_addr, 32'h400);
            chk($sformatf("lh_be_c%0d", c), mem_be, 4'b1100);
            chk($sformatf("lh_done_c%0d", c), done, 0);
            step();
        end
        chk("lh_req_c5", mem_req, 1);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        exp_v = exp_q.pop_front();
        chk("lh_done_c6", done, 1); chk("lh_err", err, 0); chk("lh_rdata", rdata, exp_v);
        step();

        // invalid funct3: load 011, store 100
        issue(0, 0, 3'b011, 32'h100, 32'd0);
        chk("badld_req", mem_req, 0); chk("badld_done", done, 1); chk("badld_err", err, 1);
        step();
        issue(0, 1, F3_BU, 32'h100, 32'd0);
        chk("badst_req", mem_req, 0); chk("badst_err", err, 1);
        chk("badst_rdata", rdata, 32'hFFFF8001);
        step();

        // timeout instance: ack on the last allowed cycle (4) still succeeds
        mem_rdata = 32'hCAFEF00D;
        issue(1, 0, F3_W, 32'h500, 32'd0);
        step(); step(); step();
        chk("t_last_req", mem_req_t, 1);
        mem_ack_t = 1'b1; step(); mem_ack_t = 1'b0;
        chk("t_last_done", done_t, 1); chk("t_last_err", err_t, 0);
        chk("t_last_rdata", rdata_t, 32'hCAFEF00D);
        step();

        // timeout: no ack
        mem_rdata = 32'h0BADBEEF;
        issue(1, 0, F3_W, 32'h600, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to_req_c%0d", c), mem_req_t, 1);
            chk($sformatf("to_done_c%0d", c), done_t, 0);
            step();
        end
        chk("to_done", done_t, 1); chk("to_err", err_t, 1);
        chk("to_req_drop", mem_req_t, 0); chk("to_rdata", rdata_t, 32'hCAFEF00D);
        step();
        chk("to_idle", busy_t, 0);

        // misaligned LW 0x101
        mem_rdata = 32'h11223344;
        issue(0, 0, F3_W, 32'h101, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_req", mem_req, 0); chk("mis_done", done, 1); chk("mis_err", err, 1);
        step();
`else
        chk("mis_req", mem_req, 1); chk("mis_addr", mem_addr, 32'h100);
        chk("mis_be", mem_be, 4'b1111);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk("mis_err", err, 0); chk("mis_rdata", rdata, 32'h11223344);
        step();
`endif

        // asynchronous reset while in REQ
        issue(0, 0, F3_W, 32'h700, 32'd0);
        chk("ar_req_before", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_req", mem_req, 0); chk("ar_busy", busy, 0);
        chk("ar_rdata", rdata, 0); chk("ar_state", 32'(state_dbg), 32'(S_IDLE));
        step();
        reset = 1'b0;
        step();
        chk("ar_after", busy, 0);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core's memory stage. It consumes the ALU result as the effective address and drives a single-outstanding, request/acknowledge data-memory bus. It performs byte-lane steering and write byte enables for stores, and sign or zero extension for loads. The execute stage waits on `busy` and takes write-back data when `done` pulses.

## Interface
- `XLEN`, 32: data and address width; only 32 is supported.
- `TIMEOUT`, 255: maximum cycles spent waiting for `mem_ack` before the access is aborted. Must be ≥1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe from execute; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr`  in  XLEN  effective address (ALU result).
- `wdata`  in  XLEN  store data (rs2), right-aligned.
- `busy`  out  1  high from the cycle after an accepted `start` until `done` inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = access faulted.
- `rdata`  out  XLEN  extended load data; held until the next accepted `start`.
- `mem_req`  out  1  bus request; held until acknowledged.
- `mem_we`  out  1  bus write.
- `mem_be`  out  4  byte enables.
- `mem_addr`  out  XLEN  word address; bits [1:0] are always 0.
- `mem_wdata`  out  XLEN  lane-steered store data.
- `mem_rdata`  in  XLEN  read data; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  bus acknowledge.

## Operation
- States are IDLE, REQ and DONE.
- **IDLE**
  - `start`=1 with a valid `funct3` latches `we`, `funct3`, `addr` and `wdata`, clears the timeout counter, and moves to REQ.
  - `start`=1 with an invalid `funct3` (011, 110, 111 for loads; anything other than 000/001/010 for stores) moves to DONE with `err`=1 and no bus cycle.
- **REQ**
  - `mem_req`=1. `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are driven from latched values and stay stable until `mem_ack`.
  - `mem_ack`=1: capture `mem_rdata` through the load extender; go to DONE with `err`=0.
  - Otherwise the counter increments. When it reaches `TIMEOUT`, deassert `mem_req`, go to DONE with `err`=1, and leave `rdata` unchanged.
- **DONE**
  - `done`=1 for exactly one cycle, then return to IDLE.
  - `start` in DONE is ignored. The earliest new accept is the cycle after DONE.
- Byte enables by access size:
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << {addr[1],1'b0}`.
  - W: `4'b1111`.
- Store lane replication:
  - B: `{4{wdata[7:0]}}`.
  - H: `{2{wdata[15:0]}}`.
  - W: `wdata`.
- Loads select the byte or halfword lane from `addr[1:0]`. LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- `mem_ack` outside REQ is ignored. `start` outside IDLE is ignored.
- Reset mid-access drops `mem_req` immediately and forces IDLE. The bus slave must tolerate an abandoned request.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `rdata`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0. State = IDLE, counter = 0.
- Latency with `start` at cycle 0:
  - `mem_req` rises at cycle 1.
  - If ack arrives at cycle k (k≥1), `done` is high at cycle k+1.
  - Minimum is 2 cycles from `start` to `done`.
- Timeout: with no ack, `done`/`err` are high at cycle `TIMEOUT`+1.
- `busy` is high in REQ and DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0, goes IDLE→DONE with `err`=1 and no bus cycle.
- Not defined:
  - Misalignment never faults.
  - Offending low address bits are cleared: H clears `addr[0]`, W clears `addr[1:0]`. The access proceeds aligned.

## Structure
- `lsu_pkg` holds:
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The state enum.
  - A `be_for(size, offset)` function.
- One sub-module, `load_extend`: combinational lane select and sign/zero extension (`mem_rdata`, `addr[1:0]`, `funct3` → `XLEN` result). It is instantiated once in `lsu`.

## Test plan
- SW: `addr`=0x104, `wdata`=0xDEADBEEF, ack at cycle 1 → `mem_addr`=0x104, `mem_be`=1111, `mem_wdata`=0xDEADBEEF, `done` at cycle 2, `err`=0.
- SB: `addr`=0x203, `wdata`=0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x200.
- LB and LBU: `addr`=0x302, `mem_rdata`=0x12F04455 → LB `rdata`=0xFFFFFFF0; LBU `rdata`=0x000000F0.
- LH: `addr`=0x402, `mem_rdata`=0x8001_7FFF, ack delayed 5 cycles → `mem_req` held stable for 5 cycles; `rdata`=0xFFFF8001; `done` at cycle 6.
- No ack, `TIMEOUT`=4 → `mem_req` high for cycles 1–4; `done`=1 and `err`=1 at cycle 5; `rdata` unchanged.
- LW at `addr`=0x101:
  - With `LSU_MISALIGN_TRAP_EN`: `mem_req` never asserted; `done`/`err`=1 at cycle 1.
  - Without it: `mem_addr`=0x100.
  - Either build: assert `reset` while in REQ → `mem_req`=0 immediately.
